// File: rtl/ni_inject_buf.sv
// ni_inject_buf
// Network-interface injection buffer between a node's traffic source and the
// local router's injection port. The source streams words with no
// backpressure. Each word is filtered, then buffered in a first-word-fall-through
// FIFO, then offered to the router with a valid/ready handshake. The block
// also keeps drop, reject and throughput statistics.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   flush             synchronous clear of FIFO contents (statistics kept)
//   in_data/in_valid  source word, [15:12] src, [7:4] dest, [3:0] payload
//   out_data          FIFO head word, held when empty (zero after reset)
//   out_valid         head word valid (= !empty)
//   out_ready         router accepts the head word this cycle
//   dest_cluster      out_data[7:6]
//   dest_local        out_data[5:4]
//   count/full/empty  occupancy, 0..DEPTH
//   drop_cnt          words lost to overflow, saturating
//   bad_cnt           words rejected by the filter, saturating
//   sent_cnt          words handed to the router, wrapping

module ni_inject_buf #(
   parameter int         DEPTH   = 16,
   parameter int         AW      = 4,
   parameter logic [3:0] NODE_ID = 4'd0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic [19:0]   in_data,
   input  logic          in_valid,
   output logic [19:0]   out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [1:0]    dest_cluster,
   output logic [1:0]    dest_local,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty,
   output logic [7:0]    drop_cnt,
   output logic [7:0]    bad_cnt,
   output logic [15:0]   sent_cnt
);

   localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE    = AW'(1);

   logic [19:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] rd_next;
   logic [AW:0]   count_next;
   logic [19:0]   head_next;
   logic          accept;
   logic          do_push;
   logic          do_pop;
   logic          do_drop;
   logic          do_bad;
   logic          room;

   assign out_valid    = (count != '0);
   assign empty        = (count == '0);
   assign full         = (count == FULL_COUNT);
   assign dest_cluster = out_data[7:6];
   assign dest_local   = out_data[5:4];

   // Event decode. Flush suppresses every event so that no pointer or
   // statistic moves in a flush cycle. A full FIFO still has room when
   // the head leaves in the same cycle.
   // The head register is loaded with the word that will sit at rd_next
   // after this edge. When the FIFO is empty, or holds only the word now
   // being popped, that word is the one arriving this cycle. It is not in
   // mem yet, so it is taken straight from in_data.
   always_comb begin
      accept     = 1'b0;
      do_pop     = 1'b0;
      room       = 1'b0;
      do_push    = 1'b0;
      do_drop    = 1'b0;
      do_bad     = 1'b0;
      rd_next    = rd_ptr;
      count_next = count;
      head_next  = out_data;

      accept  = in_valid && (in_data[15:12] == NODE_ID) && (in_data[7:4] != NODE_ID);
      do_pop  = out_valid && out_ready && !flush;
      room    = (count != FULL_COUNT) || do_pop;
      do_push = accept && room && !flush;
      do_drop = accept && !room && !flush;
      do_bad  = in_valid && !accept && !flush;

      if (do_pop)
         rd_next = rd_ptr + PTR_ONE;

      if (flush)
         count_next = '0;
      else if (do_push && !do_pop)
         count_next = count + CNT_ONE;
      else if (do_pop && !do_push)
         count_next = count - CNT_ONE;

      if (count_next != '0) begin
         if (do_push && (wr_ptr == rd_next))
            head_next = in_data;
         else
            head_next = mem[rd_next];
      end
   end

   // Storage array. It carries no reset because the head register and
   // count decide what is visible.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= in_data;
   end

   // Pointers, occupancy, head register and statistics
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         out_data <= '0;
         drop_cnt <= '0;
         bad_cnt  <= '0;
         sent_cnt <= '0;
      end else begin
         count    <= count_next;
         out_data <= head_next;
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (do_push)
               wr_ptr <= wr_ptr + PTR_ONE;
            rd_ptr <= rd_next;
         end
         if (do_drop && (drop_cnt != 8'hFF))
            drop_cnt <= drop_cnt + 8'd1;
         if (do_bad && (bad_cnt != 8'hFF))
            bad_cnt <= bad_cnt + 8'd1;
         if (do_pop)
            sent_cnt <= sent_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_ni_inject_buf.sv
// tb_ni_inject_buf
// Directed self-checking bench for ni_inject_buf with NODE_ID=5 and DEPTH=16.
// Inputs change 1 time unit after each rising edge, and outputs are sampled
// at the same point. Expected values are worked out by hand.

module tb_ni_inject_buf;

   logic        clk;
   logic        rst;
   logic        flush;
   logic [19:0] in_data;
   logic        in_valid;
   logic [19:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  dest_cluster;
   logic [1:0]  dest_local;
   logic [4:0]  count;
   logic        full;
   logic        empty;
   logic [7:0]  drop_cnt;
   logic [7:0]  bad_cnt;
   logic [15:0] sent_cnt;

   int compareCount;
   int failCount;

   ni_inject_buf #(
      .DEPTH   (16),
      .AW      (4),
      .NODE_ID (4'd5)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .dest_cluster (dest_cluster),
      .dest_local   (dest_local),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .drop_cnt     (drop_cnt),
      .bad_cnt      (bad_cnt),
      .sent_cnt     (sent_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts one comparison and reports it when the two values differ
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compareCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drives one cycle of inputs, then waits until just after the edge
   task automatic applyStimulus(input logic v, input logic [19:0] d, input logic r, input logic f);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      flush     = f;
      @(posedge clk);
      #1;
   endtask

   // Filter-passing word with a unique pattern per index (src 5, dest 9)
   function automatic logic [19:0] mkFill(input int k);
      logic [7:0] kb;
      kb = k[7:0];
      return {3'b000, kb[4], 4'h5, kb[3:0], 4'h9, ~kb[3:0]};
   endfunction

   logic [19:0] burst [15];
   logic [19:0] wordX;
   logic [19:0] wordY;
   logic [19:0] wordZ;

   initial begin
      compareCount = 0;
      failCount    = 0;
      rst       = 1'b0;
      flush     = 1'b0;
      in_data   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      wordX     = 20'hF5EA7;
      wordY     = 20'h05C12;
      wordZ     = 20'h15B34;

      // Reset state
      #2;
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_empty", empty, 1);
      checkOutput("rst_full", full, 0);
      checkOutput("rst_count", count, 0);
      checkOutput("rst_out_data", out_data, 0);
      checkOutput("rst_dest", {dest_cluster, dest_local}, 0);
      checkOutput("rst_counters", {drop_cnt, bad_cnt, sent_cnt}, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Burst of 15 words with the router always ready
      begin
         int n;
         n = 0;
         for (int i = 15; i >= 0; i--) begin
            if (i != 5) begin
               logic [3:0] d;
               d = i[3:0];
               burst[n] = {12'h050, d, d};
               n++;
            end
         end
      end
      for (int i = 0; i < 15; i++) begin
         applyStimulus(1'b1, burst[i], 1'b1, 1'b0);
         checkOutput($sformatf("burst_valid_%0d", i), out_valid, 1);
         checkOutput($sformatf("burst_data_%0d", i), out_data, burst[i]);
         checkOutput($sformatf("burst_dest_%0d", i), {dest_cluster, dest_local}, burst[i][7:4]);
         checkOutput($sformatf("burst_count_%0d", i), count, 1);
      end
      applyStimulus(1'b0, 20'h0, 1'b1, 1'b0);
      checkOutput("burst_empty", empty, 1);
      checkOutput("burst_hold_data", out_data, burst[14]);
      checkOutput("burst_sent", sent_cnt, 15);
      checkOutput("burst_drop", drop_cnt, 0);
      checkOutput("burst_bad", bad_cnt, 0);

      // Fill past capacity with the router stalled
      for (int k = 0; k < 20; k++) begin
         applyStimulus(1'b1, mkFill(k), 1'b0, 1'b0);
         checkOutput($sformatf("fill_head_%0d", k), out_data, mkFill(0));
         if (k == 14) checkOutput("fill_notfull_15", full, 0);
         if (k == 15) begin
            checkOutput("fill_full_16", full, 1);
            checkOutput("fill_drop_16", drop_cnt, 0);
         end
      end
      checkOutput("fill_count", count, 16);
      checkOutput("fill_drop", drop_cnt, 4);
      for (int j = 0; j < 16; j++) begin
         checkOutput($sformatf("drain_valid_%0d", j), out_valid, 1);
         checkOutput($sformatf("drain_data_%0d", j), out_data, mkFill(j));
         applyStimulus(1'b0, 20'h0, 1'b1, 1'b0);
      end
      checkOutput("drain_empty", empty, 1);
      checkOutput("drain_count", count, 0);
      checkOutput("drain_sent", sent_cnt, 31);

      // Push and pop together while full
      for (int k = 0; k < 16; k++)
         applyStimulus(1'b1, mkFill(k), 1'b0, 1'b0);
      checkOutput("refill_full", full, 1);
      applyStimulus(1'b1, wordX, 1'b1, 1'b0);
      checkOutput("pushpop_count", count, 16);
      checkOutput("pushpop_drop", drop_cnt, 4);
      checkOutput("pushpop_sent", sent_cnt, 32);
      checkOutput("pushpop_head", out_data, mkFill(1));
      for (int j = 1; j < 17; j++) begin
         checkOutput($sformatf("pp_drain_%0d", j), out_data, (j == 16) ? wordX : mkFill(j));
         applyStimulus(1'b0, 20'h0, 1'b1, 1'b0);
      end
      checkOutput("pp_empty", empty, 1);
      checkOutput("pp_sent", sent_cnt, 48);

      // Filter rejects and saturation of the reject counter
      applyStimulus(1'b1, 20'h030FF, 1'b0, 1'b0);
      applyStimulus(1'b1, 20'h05055, 1'b0, 1'b0);
      checkOutput("filter_bad", bad_cnt, 2);
      checkOutput("filter_empty", empty, 1);
      for (int i = 0; i < 300; i++)
         applyStimulus(1'b1, {4'h0, 4'h3, 4'h0, 4'h1, 4'(i)}, 1'b0, 1'b0);
      checkOutput("filter_sat", bad_cnt, 255);
      checkOutput("filter_count", count, 0);
      checkOutput("filter_drop", drop_cnt, 4);

      // Flush with a concurrent push
      for (int k = 0; k < 7; k++)
         applyStimulus(1'b1, mkFill(k), 1'b0, 1'b0);
      checkOutput("preflush_count", count, 7);
      applyStimulus(1'b1, mkFill(20), 1'b1, 1'b1);
      checkOutput("flush_count", count, 0);
      checkOutput("flush_empty", empty, 1);
      checkOutput("flush_valid", out_valid, 0);
      checkOutput("flush_counters", {drop_cnt, bad_cnt, sent_cnt}, {8'd4, 8'd255, 16'd48});
      applyStimulus(1'b1, wordY, 1'b0, 1'b0);
      checkOutput("postflush_valid", out_valid, 1);
      checkOutput("postflush_data", out_data, wordY);
      checkOutput("postflush_count", count, 1);
      applyStimulus(1'b0, 20'h0, 1'b1, 1'b0);
      checkOutput("postflush_sent", sent_cnt, 49);
      checkOutput("postflush_empty", empty, 1);

      // Asynchronous reset with words held
      for (int k = 0; k < 5; k++)
         applyStimulus(1'b1, mkFill(k), 1'b0, 1'b0);
      checkOutput("prereset_count", count, 5);
      in_valid = 1'b0;
      rst = 1'b0;
      #1;
      checkOutput("areset_valid", out_valid, 0);
      checkOutput("areset_count", count, 0);
      checkOutput("areset_data", out_data, 0);
      checkOutput("areset_counters", {drop_cnt, bad_cnt, sent_cnt}, 0);
      applyStimulus(1'b1, wordZ, 1'b0, 1'b0);
      checkOutput("inreset_count", count, 0);
      rst = 1'b1;
      applyStimulus(1'b1, wordZ, 1'b0, 1'b0);
      checkOutput("resume_valid", out_valid, 1);
      checkOutput("resume_data", out_data, wordZ);
      checkOutput("resume_dest", {dest_cluster, dest_local}, 4'h3);
      applyStimulus(1'b0, 20'h0, 1'b1, 1'b0);
      checkOutput("resume_sent", sent_cnt, 1);
      checkOutput("resume_empty", empty, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
